// File: rtl/somador_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor family.
`ifndef SOMADOR_PKG_SV
`define SOMADOR_PKG_SV

// Elaboration-time guard: the operand must split into whole chunks.
`define SOMADOR_ASSERT_DIV(w, sw) \
   if (((w) % (sw)) != 0) begin : g_bad_width \
      $error("somador: WIDTH must be a multiple of STAGE_W"); \
   end

package somador_pkg;

   typedef struct packed {
      logic valid;
      logic carry;
   } stg_ctl_t;

   function automatic int nstg(input int width, input int stage_w);
      return width / stage_w;
   endfunction

endpackage

`endif

// File: rtl/somador_bloco.sv
// Combinational W-bit ripple chain; also exposes the carry into the MSB for overflow detection.
module somador_bloco #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         c_msb
);

   // Each cell owns its carry signals so the chain is not a self-referencing vector.
   for (genvar i = 0; i < W; i++) begin : g_fa
      logic ci;
      logic co;
      if (i == 0) begin : g_lsb
         assign ci = cin;
      end else begin : g_rest
         assign ci = g_fa[i-1].co;
      end
      somadorcompleto u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (ci),
         .s    (s[i]),
         .cout (co)
      );
   end

   assign cout  = g_fa[W-1].co;
   assign c_msb = g_fa[W-1].ci;

endmodule

// File: rtl/somadorcompleto.sv
// One-bit full adder cell, the building block of every ripple chain.
module somadorcompleto (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/somador_pipe_nb.sv
// Pipelined WIDTH-bit adder/subtractor: one STAGE_W chunk per stage, registered carry between stages,
// with a single global stall so the whole pipe (output register included) advances together.
module somador_pipe_nb
   import somador_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int STAGE_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int NSTG = nstg(WIDTH, STAGE_W);

   `SOMADOR_ASSERT_DIV(WIDTH, STAGE_W)

   stg_ctl_t         ctl_q [NSTG];
   logic [WIDTH-1:0] a_q   [NSTG];
   logic [WIDTH-1:0] b_q   [NSTG];
   logic [WIDTH-1:0] s_q   [NSTG];
   logic [NSTG-1:0]  co_v;
   logic [NSTG-1:0]  cmsb_v;
   logic             ovf_q;
   logic             adv;
   logic             unused_skew;

   assign adv       = ~ctl_q[NSTG-1].valid | out_ready;
   assign in_ready  = adv;
   assign out_valid = ctl_q[NSTG-1].valid;
   assign s         = s_q[NSTG-1];
   assign cout      = ctl_q[NSTG-1].carry;
   assign ovf       = ovf_q;

   // The last stage's skew operands and the lower stages' MSB carries have no consumer.
   assign unused_skew = ^{a_q[NSTG-1], b_q[NSTG-1], cmsb_v};

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      logic [WIDTH-1:0]   a_k;
      logic [WIDTH-1:0]   b_k;
      logic [WIDTH-1:0]   s_k;
      logic [WIDTH-1:0]   s_nx;
      logic [STAGE_W-1:0] sum;
      logic               c_k;
      logic               v_k;

      // Subtraction is folded into stage 0 as a + ~b + ~cin; later stages only see b_eff.
      if (k == 0) begin : g_first
         assign a_k = a;
         assign b_k = sub ? ~b : b;
         assign s_k = '0;
         assign c_k = sub ? ~cin : cin;
         assign v_k = in_valid;
      end else begin : g_next
         assign a_k = a_q[k-1];
         assign b_k = b_q[k-1];
         assign s_k = s_q[k-1];
         assign c_k = ctl_q[k-1].carry;
         assign v_k = ctl_q[k-1].valid;
      end

      somador_bloco #(.W(STAGE_W)) u_bloco (
         .a     (a_k[k*STAGE_W +: STAGE_W]),
         .b     (b_k[k*STAGE_W +: STAGE_W]),
         .cin   (c_k),
         .s     (sum),
         .cout  (co_v[k]),
         .c_msb (cmsb_v[k])
      );

      always_comb begin
         s_nx                         = s_k;
         s_nx[k*STAGE_W +: STAGE_W]   = sum;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            ctl_q[k] <= '0;
            s_q[k]   <= '0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
         end else if (adv) begin
            ctl_q[k] <= '{valid: v_k, carry: co_v[k]};
            s_q[k]   <= s_nx;
            a_q[k]   <= a_k;
            b_q[k]   <= b_k;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= co_v[NSTG-1] ^ cmsb_v[NSTG-1];
      end
   end

endmodule

// File: tb/tb_somador_pipe_nb.sv
// Scoreboard bench for somador_pipe_nb (16-bit, 4-bit stages): directed vectors, stall and reset scenarios.
module tb_somador_pipe_nb;

   typedef struct packed {
      logic [15:0] s;
      logic        cout;
      logic        ovf;
   } res_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        cout;
      logic        ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] s;
   logic        cout;
   logic        ovf;

   res_t expq[$];
   vec_t dirv[10];
   vec_t strv[8];
   int   total     = 0;
   int   bad       = 0;
   int   pushed    = 0;
   int   delivered = 0;

   always #5 clk = ~clk;

   somador_pipe_nb #(.WIDTH(16), .STAGE_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf)
   );

   function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vcin,
                               input logic vsub, input logic [15:0] vs, input logic vco, input logic vov);
      vec_t v;
      v.a = va; v.b = vb; v.cin = vcin; v.sub = vsub;
      v.s = vs; v.cout = vco; v.ovf = vov;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Drive one beat, wait (bounded) for in_ready, record the expected result at the accepting edge.
   task automatic applyStimulus(input vec_t v);
      int   waited;
      res_t r;
      waited   = 0;
      a        = v.a;
      b        = v.b;
      cin      = v.cin;
      sub      = v.sub;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (in_ready) begin
         r.s = v.s; r.cout = v.cout; r.ovf = v.ovf;
         expq.push_back(r);
         pushed++;
      end else begin
         checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
         in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n        = 0;
      in_valid = 1'b0;
      while (expq.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkOutput("drain_empty", expq.size(), 32'd0);
   endtask

   task automatic pulseReset();
      in_valid = 1'b0;
      rst      = 1'b1;
      pushed   = pushed - expq.size();
      expq.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: compare the head of the scoreboard whenever a result is presented.
   always @(negedge clk) begin
      if (rst !== 1'b1 && out_valid === 1'b1) begin
         if (expq.size() == 0) begin
            checkOutput("unexpected_beat", 32'd1, 32'd0);
         end else begin
            checkOutput("s", {16'b0, s}, {16'b0, expq[0].s});
            checkOutput("cout", {31'b0, cout}, {31'b0, expq[0].cout});
            checkOutput("ovf", {31'b0, ovf}, {31'b0, expq[0].ovf});
            if (out_ready) begin
               void'(expq.pop_front());
               delivered++;
            end else begin
               checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      dirv[0] = mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      dirv[1] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      dirv[2] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      dirv[3] = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      dirv[4] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      dirv[5] = mk(16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0);
      dirv[6] = mk(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
      dirv[7] = mk(16'h0007, 16'h0003, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b0);
      dirv[8] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      dirv[9] = mk(16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

      strv[0] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      strv[1] = mk(16'h0001, 16'h0003, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      strv[2] = mk(16'h0002, 16'h0006, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0);
      strv[3] = mk(16'h0003, 16'h0009, 1'b0, 1'b1, 16'hFFFA, 1'b0, 1'b0);
      strv[4] = mk(16'h0004, 16'h000C, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
      strv[5] = mk(16'h0005, 16'h000F, 1'b0, 1'b1, 16'hFFF6, 1'b0, 1'b0);
      strv[6] = mk(16'h0006, 16'h0012, 1'b0, 1'b0, 16'h0018, 1'b0, 1'b0);
      strv[7] = mk(16'h0007, 16'h0015, 1'b0, 1'b1, 16'hFFF2, 1'b0, 1'b0);

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] reset state");
      @(negedge clk);
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_s", {16'b0, s}, 32'd0);
      checkOutput("rst_cout", {31'b0, cout}, 32'd0);
      checkOutput("rst_ovf", {31'b0, ovf}, 32'd0);
      checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      $display("[TB] single beat latency");
      applyStimulus(dirv[0]);
      in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (out_valid !== 1'b1 && n < 20);
      checkOutput("latency", n, 32'd4);
      drain();

      $display("[TB] directed vectors back to back");
      for (int i = 1; i < 10; i++) applyStimulus(dirv[i]);
      drain();

      $display("[TB] alternating add/sub stream");
      for (int i = 0; i < 8; i++) applyStimulus(strv[i]);
      drain();

      $display("[TB] stream with consumer stall");
      fork
         begin
            for (int i = 0; i < 10; i++) applyStimulus(dirv[i]);
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      $display("[TB] reset with beats in flight");
      for (int i = 0; i < 3; i++) applyStimulus(strv[i + 1]);
      pulseReset();
      @(negedge clk);
      checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("flush_s", {16'b0, s}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("flush_no_stale", {31'b0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      applyStimulus(mk(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0));
      drain();

      checkOutput("beat_count", delivered, pushed);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
